// File: rtl/count_display_pkg.sv
// count_display_pkg
//   Shared definitions for the count_display slice: FSM state encoding,
//   active-low 7-segment glyph constants ({g,f,e,d,c,b,a}) and the
//   double-dabble nibble adjust helper.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs for decimal digits 0..9, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the
  // shift so that it carries correctly into the next decimal digit.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder
//   Converts one BCD digit to an active-low 7-segment pattern.
//   Ports:
//     digit  in   4   BCD digit; values above 9 render blank
//     blank  in   1   force all segments off
//     seg    out  7   {g,f,e,d,c,b,a}, active-low
module seven_seg_decoder
  import count_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/count_display.sv
// count_display
//   Converts a binary population count to BCD with a one-bit-per-clock
//   double-dabble FSM and drives registered active-low 7-segment digits.
//   A conversion only starts when the input differs from the last converted
//   value (or after reset), so the display outputs hold steady between updates.
//   Ports:
//     clk    in   1             rising-edge clock
//     rst_n  in   1             asynchronous active-low reset
//     count  in   IN_WIDTH      binary value, sampled only while idle
//     bcd    out  4*DIGITS      converted value, LSD in [3:0]
//     hex    out  7*DIGITS      7-seg per digit, hex[7i+6:7i] = {g,f,e,d,c,b,a}
//     busy   out  1             conversion in progress (SHIFT or DONE)
//     done   out  1             one-cycle pulse when bcd/hex update
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 11,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);

  if (10 ** DIGITS <= 2 ** IN_WIDTH - 1) begin : g_digits_check
    $error("count_display: DIGITS too small to hold 2**IN_WIDTH-1");
  end

  state_t              state;
  logic [IN_WIDTH-1:0] shreg;
  logic [IN_WIDTH-1:0] cap;
  logic [IN_WIDTH-1:0] last_val;
  logic [BW-1:0]       work;
  logic [BW-1:0]       work_adj;
  logic [CW-1:0]       bit_cnt;
  logic                force_conv;
  logic [DIGITS-1:0]   blank;
  logic                higher_zero;
  logic [7*DIGITS-1:0] seg_next;

  // Per-nibble +3 adjust applied before every shift.
  always_comb begin
    work_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      work_adj[4*i +: 4] = add3_nibble(work[4*i +: 4]);
    end
  end

  // Leading-zero blanking: scan from the most significant digit downwards;
  // a digit is blank while it and everything above it is zero. Digit 0 is
  // never blanked so a value of zero still shows '0'.
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      higher_zero = higher_zero && (work[4*(DIGITS-1-k) +: 4] == 4'd0);
      blank[DIGITS-1-k] = (BLANK_LEADING != 0) && higher_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seven_seg_decoder u_dec (
      .digit (work[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_next[7*g +: 7])
    );
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cap        <= '0;
      last_val   <= '0;
      work       <= '0;
      bit_cnt    <= '0;
      force_conv <= 1'b1;
      bcd        <= '0;
      done       <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        hex[7*i +: 7] <= ((i == 0) || (BLANK_LEADING == 0)) ? SEG_DIGIT[0] : SEG_BLANK;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (force_conv || (count != last_val)) begin
            shreg      <= count;
            cap        <= count;
            work       <= '0;
            bit_cnt    <= CW'(IN_WIDTH);
            force_conv <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // {work, shreg} <<= 1 after the add-3 correction.
          work    <= {work_adj[BW-2:0], shreg[IN_WIDTH-1]};
          shreg   <= {shreg[IN_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= work;
          hex      <= seg_next;
          last_val <= cap;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_display.sv
module tb_count_display;

  logic        clk;
  logic        rst_n;
  logic [10:0] count;
  logic [15:0] bcd;
  logic [27:0] hex;
  logic        busy;
  logic        done;

  int unsigned n_pass;
  int unsigned n_total;

  localparam logic [27:0] HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'h40};

  count_display #(
    .IN_WIDTH      (11),
    .DIGITS        (4),
    .BLANK_LEADING (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count),
    .bcd   (bcd),
    .hex   (hex),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int unsigned value;
    logic [15:0] exp_bcd;
    logic [27:0] exp_hex;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: integer to decimal digits, glyph table, leading-zero blanking.
  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [27:0] ref_hex(input int unsigned v);
    logic [27:0] r;
    r[6:0]   = ref_seg(int'(v % 10));
    r[13:7]  = (v >= 10)   ? ref_seg(int'((v / 10) % 10))   : 7'h7F;
    r[20:14] = (v >= 100)  ? ref_seg(int'((v / 100) % 10))  : 7'h7F;
    r[27:21] = (v >= 1000) ? ref_seg(int'((v / 1000) % 10)) : 7'h7F;
    return r;
  endfunction

  // Returns the number of rising edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int n, output logic busy1);
    n = -1;
    busy1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (done) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic convert(input string tag, input int unsigned v,
                         input logic [15:0] eb, input logic [27:0] eh);
    int   n;
    logic b1;
    count = 11'(v);
    wait_done(n, b1);
    chk({tag, "_busy"}, 32'(b1), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd13);
    chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
    chk({tag, "_hex"}, 32'(hex), 32'(eh));
  endtask

  vec_t vecs [8];

  initial begin
    int          n;
    logic        b1;
    int unsigned ndone;
    logic [15:0] seen [2];
    logic        bad;
    logic [15:0] hold_bcd;
    logic [27:0] hold_hex;
    int unsigned prev;
    int unsigned v;

    vecs[0] = '{1234, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{2047, 16'h2047, {7'h24, 7'h40, 7'h19, 7'h78}};
    vecs[2] = '{100,  16'h0100, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[3] = '{5,    16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[4] = '{999,  16'h0999, {7'h7F, 7'h10, 7'h10, 7'h10}};
    vecs[5] = '{1000, 16'h1000, {7'h79, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{10,   16'h0010, {7'h7F, 7'h7F, 7'h79, 7'h40}};
    vecs[7] = '{0,    16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};

    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    count   = '0;

    // 1: reset state, then forced conversion of 0 after release.
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_hex", 32'(hex), 32'(HEX_RST));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    wait_done(n, b1);
    chk("t1_busy", 32'(b1), 32'd1);
    chk("t1_latency", 32'(n), 32'd13);
    chk("t1_bcd", 32'(bcd), 32'h0);
    chk("t1_hex", 32'(hex), 32'(HEX_RST));

    // 2/3: directed table.
    for (int i = 0; i < 8; i++) begin
      convert($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_bcd, vecs[i].exp_hex);
    end

    // 4: input change mid-conversion.
    count = 11'd5;
    ndone = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("t4_busy3", 32'(busy), 32'd1);
        count = 11'd999;
      end
      if (done) begin
        if (ndone < 2) seen[ndone] = bcd;
        ndone++;
      end
    end
    chk("t4_ndone", 32'(ndone), 32'd2);
    chk("t4_first", 32'(seen[0]), 32'h0005);
    chk("t4_second", 32'(seen[1]), 32'h0999);
    chk("t4_hex", 32'(hex), 32'({7'h7F, 7'h10, 7'h10, 7'h10}));

    // 5: reset mid-SHIFT aborts, then reconverts the current count.
    count = 11'd77;
    repeat (5) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("t5_bcd", 32'(bcd), 32'h0);
    chk("t5_hex", 32'(hex), 32'(HEX_RST));
    chk("t5_busy", 32'(busy), 32'd0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    chk("t5_quiet_in_reset", 32'(bad), 32'd0);
    rst_n = 1'b1;
    wait_done(n, b1);
    chk("t5_latency", 32'(n), 32'd13);
    chk("t5_bcd_after", 32'(bcd), 32'h0077);
    chk("t5_hex_after", 32'(hex), 32'({7'h7F, 7'h7F, 7'h78, 7'h78}));

    // 6: stable input, no activity.
    hold_bcd = bcd;
    hold_hex = hex;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done || bcd !== hold_bcd || hex !== hold_hex) bad = 1'b1;
    end
    chk("t6_stable", 32'(bad), 32'd0);

    // Random values against the reference model.
    prev = 77;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(2047);
      if (v == prev) v = (v + 1) % 2048;
      convert($sformatf("rnd%0d", i), v, ref_bcd(v), ref_hex(v));
      prev = v;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
